// File: rtl/water_pump_ctrl.sv
// Tank pump controller: probe sync/debounce, level bar,
// hysteresis fill FSM with sensor-fault and dry-run latching.
module water_pump_ctrl #(
  parameter int DEB_CYCLES   = 16,
  parameter int LOW_LEVEL    = 1,
  parameter int HIGH_LEVEL   = 5,
  parameter int FILL_TIMEOUT = 1000,
  parameter int TMO_W        = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s1,
  input  logic       s2,
  input  logic       s3,
  input  logic       s4,
  input  logic       s5,
  input  logic       enable,
  input  logic       clear_fault,
  output logic       pump_on,
  output logic [2:0] level,
  output logic [4:0] led,
  output logic       sensor_fault,
  output logic       dry_run,
  output logic [1:0] state
);

  localparam int DW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [2:0] LOW_L = 3'(LOW_LEVEL);
  localparam logic [2:0] HIGH_L = 3'(HIGH_LEVEL);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(FILL_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FILL   = 2'b01,
    ST_FAULT  = 2'b10,
    ST_DRYRUN = 2'b11
  } state_t;

  // bit 0 is the bottom probe so a valid pattern is 2^n-1
  logic [4:0] w_raw;
  assign w_raw = {s1, s2, s3, s4, s5};

  logic [4:0]       r_meta;
  logic [4:0]       r_sync;
  logic [4:0]       r_deb;
  logic [DW-1:0]    r_cnt [5];
  logic [2:0]       r_level;
  logic [2:0]       r_prev;
  logic [4:0]       r_led;
  logic             r_valid;
  logic [TMO_W-1:0] r_tmo;
  state_t           r_state;
  state_t           w_next;
  logic [2:0]       w_lvl;
  logic             w_valid;
  logic             w_rise;

  // two-flop synchroniser for the asynchronous probes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= w_raw;
      r_sync <= r_meta;
    end
  end

  // per-probe debounce: accept a change after DEB_CYCLES mismatches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_deb <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (r_sync[i] != r_deb[i]) begin
          if (r_cnt[i] == DEB_LAST) begin
            r_deb[i] <= r_sync[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + DW'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // thermometer check and level decode of debounced probes
  always_comb begin
    w_valid = 1'b1;
    w_lvl   = 3'd0;
    case (r_deb)
      5'b00000: w_lvl = 3'd0;
      5'b00001: w_lvl = 3'd1;
      5'b00011: w_lvl = 3'd2;
      5'b00111: w_lvl = 3'd3;
      5'b01111: w_lvl = 3'd4;
      5'b11111: w_lvl = 3'd5;
      default:  w_valid = 1'b0;
    endcase
  end

  // registered level, bar and previous level for rise detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_level <= '0;
      r_prev  <= '0;
      r_led   <= '0;
      r_valid <= 1'b1;
    end else begin
      r_level <= w_lvl;
      r_prev  <= r_level;
      r_led   <= w_valid ? r_deb : 5'b00000;
      r_valid <= w_valid;
    end
  end

  assign w_rise = (r_level > r_prev);

  // fill state machine next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!r_valid) w_next = ST_FAULT;
        else if (enable && (r_level <= LOW_L)) w_next = ST_FILL;
      end
      ST_FILL: begin
        if (!r_valid) w_next = ST_FAULT;
        else if ((r_tmo == TMO_LAST) && !w_rise) w_next = ST_DRYRUN;
        else if (r_level >= HIGH_L) w_next = ST_IDLE;
        else if (!enable) w_next = ST_IDLE;
      end
      ST_FAULT: begin
        if (clear_fault && r_valid) w_next = ST_IDLE;
      end
      default: begin
        if (clear_fault) w_next = ST_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // dry-run counter: counts quiet FILL cycles, zero elsewhere
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if ((r_state == ST_FILL) && (w_next == ST_FILL) && !w_rise) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end else begin
      r_tmo <= '0;
    end
  end

  assign pump_on      = (r_state == ST_FILL);
  assign sensor_fault = (r_state == ST_FAULT);
  assign dry_run      = (r_state == ST_DRYRUN);
  assign state        = r_state;
  assign level        = r_level;
  assign led          = r_led;

endmodule

// File: tb/tb_water_pump_ctrl.sv
// Randomised bench for water_pump_ctrl against a
// behavioural tank/pump model.
module tb_water_pump_ctrl;

  localparam int DEB = 4;
  localparam int LOW = 1;
  localparam int HIGH = 5;
  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] raw = 5'b11111;
  logic       enable = 1'b1;
  logic       clear_fault = 1'b0;
  logic       pump_on;
  logic [2:0] level;
  logic [4:0] led;
  logic       sensor_fault;
  logic       dry_run;
  logic [1:0] state;

  int n_chk = 0;
  int n_pass = 0;

  water_pump_ctrl #(
    .DEB_CYCLES(DEB),
    .LOW_LEVEL(LOW),
    .HIGH_LEVEL(HIGH),
    .FILL_TIMEOUT(TMO),
    .TMO_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s1(raw[4]),
    .s2(raw[3]),
    .s3(raw[2]),
    .s4(raw[1]),
    .s5(raw[0]),
    .enable(enable),
    .clear_fault(clear_fault),
    .pump_on(pump_on),
    .level(level),
    .led(led),
    .sensor_fault(sensor_fault),
    .dry_run(dry_run),
    .state(state)
  );

  always #5 clk = ~clk;

  // model: probe pipeline, stable-run counts, level, mode
  logic [4:0] m_sy1, m_sy2, m_deb;
  int m_run [5];
  int m_lvl, m_prev, m_mode, m_quiet;
  bit m_valid;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_sy1 = '0; m_sy2 = '0; m_deb = '0;
    for (int i = 0; i < 5; i++) m_run[i] = 0;
    m_lvl = 0; m_prev = 0; m_mode = 0; m_quiet = 0;
    m_valid = 1'b1;
  endtask

  task automatic model_edge();
    int pc, nl, nm;
    bit v, rise;
    if (!rst_n) begin
      model_reset();
      return;
    end
    pc = $countones(m_deb);
    v = (int'(m_deb) == (1 << pc) - 1);
    nl = v ? pc : 0;
    rise = (m_lvl > m_prev);
    nm = m_mode;
    // modes: 0 idle, 1 fill, 2 sensor fault, 3 dry run
    if (m_mode == 0) begin
      if (!m_valid) nm = 2;
      else if (enable && m_lvl <= LOW) nm = 1;
    end else if (m_mode == 1) begin
      if (!m_valid) nm = 2;
      else if (!rise && m_quiet + 1 >= TMO) nm = 3;
      else if (m_lvl >= HIGH || !enable) nm = 0;
    end else if (m_mode == 2) begin
      if (clear_fault && m_valid) nm = 0;
    end else begin
      if (clear_fault) nm = 0;
    end
    if (m_mode == 1 && nm == 1) m_quiet = rise ? 0 : m_quiet + 1;
    else m_quiet = 0;
    for (int i = 0; i < 5; i++) begin
      if (m_sy2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] >= DEB) begin
          m_deb[i] = m_sy2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_sy2 = m_sy1;
    m_sy1 = raw;
    m_prev = m_lvl;
    m_lvl = nl;
    m_valid = v;
    m_mode = nm;
  endtask

  task automatic compare_all();
    check("state", int'(state), m_mode);
    check("pump_on", int'(pump_on), int'(m_mode == 1));
    check("level", int'(level), m_lvl);
    check("led", int'(led), (1 << m_lvl) - 1);
    check("sensor_fault", int'(sensor_fault), int'(m_mode == 2));
    check("dry_run", int'(dry_run), int'(m_mode == 3));
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [4:0] base, cur;
    int lv, hold;
    model_reset();
    // reset with full tank and enable high
    cyc(5);
    check("rst_pump", int'(pump_on), 0);
    check("rst_state", int'(state), 0);
    rst_n = 1'b1;
    raw = 5'b00000;
    // fill from empty, one probe every 10 cycles
    cyc(5);
    for (int k = 0; k < 5; k++) begin
      raw[k] = 1'b1;
      cyc(10);
    end
    cyc(15);
    check("full_state", int'(state), 0);
    check("full_level", int'(level), 5);
    check("full_led", int'(led), 31);
    // hysteresis band, then refill, then disable
    raw = 5'b00111;
    cyc(15);
    check("band_pump", int'(pump_on), 0);
    raw = 5'b00001;
    cyc(15);
    check("low_fill", int'(pump_on), 1);
    enable = 1'b0;
    cyc(3);
    // debounce: chatter on bottom probe, then a clean step
    raw = 5'b00000;
    cyc(15);
    for (int j = 0; j < 20; j++) begin
      raw[0] = (j % 2 == 0);
      cyc(2);
    end
    raw[0] = 1'b1;
    n = 0;
    do begin
      cyc();
      n++;
    end while (level != 3'd1 && n < 30);
    check("deb_latency", n, 2 + DEB + 1);
    // sensor fault while filling
    enable = 1'b1;
    cyc(5);
    raw = 5'b01011;
    cyc(12);
    clear_fault = 1'b1;
    cyc(3);
    check("fault_hold", int'(sensor_fault), 1);
    check("fault_level", int'(level), 0);
    raw = 5'b00011;
    cyc(10);
    clear_fault = 1'b0;
    cyc(2);
    // dry run with a mid-fill rise restarting the count
    raw = 5'b00000;
    cyc(18);
    raw = 5'b00001;
    cyc(40);
    check("dry_flag", int'(dry_run), 1);
    check("dry_pump", int'(pump_on), 0);
    clear_fault = 1'b1;
    cyc(3);
    clear_fault = 1'b0;
    cyc(5);
    // randomised segments
    for (int seg = 0; seg < 120; seg++) begin
      if ($urandom_range(0, 4) == 0) begin
        lv = $urandom_range(0, 31);
        base = 5'(lv);
      end else begin
        lv = $urandom_range(0, 5);
        base = 5'((1 << lv) - 1);
      end
      enable = ($urandom_range(0, 9) != 0);
      clear_fault = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
      end
      hold = $urandom_range(1, 40);
      for (int c = 0; c < hold; c++) begin
        cur = base;
        if ($urandom_range(0, 19) == 0) begin
          lv = $urandom_range(0, 4);
          cur[lv] = ~cur[lv];
        end
        raw = cur;
        cyc();
      end
    end
    clear_fault = 1'b0;
    cyc(5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
